// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

  // Instruction substituted for fetches that fall outside instruction memory.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetched instructions. The head is visible combinationally.
// Once the queue drains, the head outputs keep the last entry that was shown.
// There is no overflow protection. The caller reserves a slot before every push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_last;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !i_clear;
  assign w_pop  = i_pop && !i_clear && (r_count != '0);

  // Entry storage: no reset, so it stays a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointer and occupancy bookkeeping. A clear empties the queue in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Track the head currently shown, so it can be held while the queue is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_last <= '0;
    else if (r_count != '0)   r_last <= r_mem[r_rd_ptr];
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue.
// It issues sequential word fetches to a synchronous instruction memory.
// It buffers the returned words with their PCs and presents them over valid/ready.
// Optional feature: define INST_FETCH_QUEUE_BYPASS_EN so that a response arriving
// at an empty queue is forwarded straight to the outputs in the same cycle.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 128*1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_mem_is_ready,
  output logic [31:0] inst_mem_address,
  input  logic        inst_mem_is_valid,
  input  logic [31:0] inst_mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AB = $clog2(IMEM_SIZE);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic          r_inflight_fault;
  logic          r_halted;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic [CW:0]   w_occupancy;
  logic          w_in_range;
  logic          w_can_issue;
  logic          w_issue;
  logic          w_fault_issue;
  logic          w_bypass;
  logic          w_pop_fire;
  logic          w_push;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign w_bypass = (w_count == '0) && r_inflight && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid  = (w_count != '0) || w_bypass;
  assign out_inst   = w_bypass ? inst_mem_read_data : w_head.inst;
  assign out_pc     = w_bypass ? r_inflight_pc      : w_head.pc;
  assign out_fault  = w_bypass ? 1'b0               : w_head.fault;
  assign w_pop_fire = out_valid && out_ready && !flush;

  // The slot freed by this cycle's pop is counted as free. This lets a request
  // restart in the same cycle that a full queue starts draining.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight}
                     - {{CW{1'b0}}, w_pop_fire};

  assign w_in_range    = ((r_fetch_pc >> AB) == 32'd0) && (r_fetch_pc[1:0] == 2'b00);
  assign w_can_issue   = !reset && !flush && !stall && !r_halted && inst_mem_is_valid
                       && (w_occupancy < DEPTH_W);
  assign w_issue       = w_can_issue && w_in_range;
  assign w_fault_issue = w_can_issue && !w_in_range;

  assign inst_mem_is_ready = w_issue;
  assign inst_mem_address  = {r_fetch_pc[31:2], 2'b00};

  // A forwarded response that is consumed the same cycle never enters the queue.
  assign w_push = (r_inflight || r_inflight_fault) && !flush && !(w_bypass && w_pop_fire);
  assign w_push_data = '{pc:    r_inflight_pc,
                         inst:  r_inflight ? inst_mem_read_data : NOP_INST,
                         fault: r_inflight_fault};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop_fire && !w_bypass),
    .i_clear     (flush),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // Fetch control: a flush redirects, a normal issue advances, an out-of-range PC halts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc       <= RESET_PC;
      r_inflight_pc    <= RESET_PC;
      r_inflight       <= 1'b0;
      r_inflight_fault <= 1'b0;
      r_halted         <= 1'b0;
    end else if (flush) begin
      r_fetch_pc       <= flush_pc;
      r_inflight       <= 1'b0;
      r_inflight_fault <= 1'b0;
      r_halted         <= 1'b0;
    end else begin
      r_inflight       <= w_issue;
      r_inflight_fault <= w_fault_issue;
      if (w_can_issue)   r_inflight_pc <= r_fetch_pc;
      if (w_issue)       r_fetch_pc    <= r_fetch_pc + 32'd4;
      if (w_fault_issue) r_halted      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed bench for inst_fetch_queue.
// The reference is a queue-based model of the fetch rules. Every cycle, the
// outputs are compared against it. A few literal expectations pin the model itself.
module tb_inst_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          IMEM_SIZE = 128*1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        inst_mem_is_ready;
  logic [31:0] inst_mem_address;
  logic        inst_mem_is_valid = 1'b0;
  logic [31:0] inst_mem_read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_SIZE(IMEM_SIZE)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .flush              (flush),
    .flush_pc           (flush_pc),
    .inst_mem_is_ready  (inst_mem_is_ready),
    .inst_mem_address   (inst_mem_address),
    .inst_mem_is_valid  (inst_mem_is_valid),
    .inst_mem_read_data (inst_mem_read_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_inst           (out_inst),
    .out_pc             (out_pc),
    .out_fault          (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  // Model state: the queue contents and the fetch stream, described abstractly.
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc;
  logic        m_pend;
  logic        m_pend_fault;
  logic [31:0] m_pend_pc;
  logic        m_halted;

  int          n_pass = 0;
  int          n_total = 0;
  int          req_pulses = 0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h3C5A_9617;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc   = RESET_PC;
    m_pend       = 1'b0;
    m_pend_fault = 1'b0;
    m_pend_pc    = '0;
    m_halted     = 1'b0;
  endtask

  // One clock cycle: drive the inputs, check the outputs against the model, then
  // advance the model to the state it has after the coming rising edge.
  task automatic step(input logic s, input logic f, input logic [31:0] fpc,
                      input logic ordy, input logic v);
    logic byp, e_valid, pop, can, in_rng, e_ready;
    int   occ;
    ent_t e;
    @(negedge clk);
    stall = s;
    flush = f;
    flush_pc = fpc;
    out_ready = ordy;
    inst_mem_is_valid = v;
    inst_mem_read_data = (m_pend && !m_pend_fault) ? imem_word(m_pend_pc) : $urandom();
    #1;
    byp = 1'b0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    byp = (m_q.size() == 0) && m_pend && !m_pend_fault && !f;
`endif
    e_valid = (m_q.size() != 0) || byp;
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    if (e_valid) begin
      if (byp) e = '{m_pend_pc, imem_word(m_pend_pc), 1'b0};
      else     e = m_q[0];
      chk("out_pc", out_pc, e.pc);
      chk("out_inst", out_inst, e.inst);
      chk("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
    end
    pop    = e_valid && ordy && !f;
    occ    = m_q.size() + int'(m_pend) - int'(pop);
    in_rng = ({32'd0, m_fetch_pc} < 64'(IMEM_SIZE)) && (m_fetch_pc[1:0] == 2'b00);
    can    = !f && !s && !m_halted && v && (occ < DEPTH);
    e_ready = can && in_rng;
    chk("req_valid", {31'd0, inst_mem_is_ready}, {31'd0, e_ready});
    if (e_ready) chk("req_addr", inst_mem_address, m_fetch_pc);
    if (inst_mem_is_ready) begin
      req_pulses++;
      last_addr = inst_mem_address;
    end
    if (f) begin
      m_q.delete();
      m_pend     = 1'b0;
      m_halted   = 1'b0;
      m_fetch_pc = fpc;
    end else begin
      if (pop && !byp) void'(m_q.pop_front());
      if (m_pend && !(byp && pop))
        m_q.push_back('{m_pend_pc, m_pend_fault ? 32'h0000_0013 : imem_word(m_pend_pc),
                        m_pend_fault});
      m_pend = can;
      if (can) begin
        m_pend_pc    = m_fetch_pc;
        m_pend_fault = !in_rng;
        if (in_rng) m_fetch_pc = m_fetch_pc + 32'd4;
        else        m_halted   = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, inst_mem_is_ready}, 32'd0);
    chk("rst_req_addr", inst_mem_address, RESET_PC);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] prev;
    logic [31:0] fpc;
    model_reset();
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_req_valid", {31'd0, inst_mem_is_ready}, 32'd0);
    chk("reset_req_addr", inst_mem_address, RESET_PC);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_fault", {31'd0, out_fault}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sequential streaming from RESET_PC.
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("first_addr", inst_mem_address, 32'h0);
    chk("first_req", {31'd0, inst_mem_is_ready}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("second_addr", inst_mem_address, 32'h4);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    chk("first_out_pc", out_pc, 32'h0);
`endif
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("third_addr", inst_mem_address, 32'h8);
`ifndef INST_FETCH_QUEUE_BYPASS_EN
    chk("first_out_valid", {31'd0, out_valid}, 32'd1);
    chk("first_out_pc", out_pc, 32'h0);
    chk("first_out_inst", out_inst, imem_word(32'h0));
`endif

    // Backpressure: only DEPTH requests fit. The first pop restarts fetching at once.
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
    base = req_pulses;
    repeat (10) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("bp_requests", 32'(req_pulses - base), 32'd4);
    chk("bp_req_low", {31'd0, inst_mem_is_ready}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("bp_resume_req", {31'd0, inst_mem_is_ready}, 32'd1);
    chk("bp_resume_addr", inst_mem_address, 32'h50);

    // Flush with three entries queued and one request in flight.
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_req_addr", inst_mem_address, 32'h100);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    chk("flush_first_pc", out_pc, 32'h100);
`endif
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
`ifndef INST_FETCH_QUEUE_BYPASS_EN
    chk("flush_first_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_first_pc", out_pc, 32'h100);
`endif

    // Running off the end of instruction memory produces one fault entry, then idles.
    step(1'b0, 1'b1, 32'h1FFF8, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("fault_valid", {31'd0, out_valid}, 32'd1);
    chk("fault_flag", {31'd0, out_fault}, 32'd1);
    chk("fault_pc", out_pc, 32'h0002_0000);
    chk("fault_inst", out_inst, 32'h0000_0013);
    base = req_pulses;
    repeat (5) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("halt_no_req", 32'(req_pulses - base), 32'd0);

    // A stall blocks requests but not responses; fetching resumes in sequence.
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    prev = last_addr;
    base = req_pulses;
    repeat (5) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("stall_no_req", 32'(req_pulses - base), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("stall_resume_req", {31'd0, inst_mem_is_ready}, 32'd1);
    chk("stall_resume_addr", inst_mem_address, prev + 32'd4);

    // Reset with two entries queued.
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    apply_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("restart_req", {31'd0, inst_mem_is_ready}, 32'd1);
    chk("restart_addr", inst_mem_address, RESET_PC);

    // Randomised traffic, including redirects near the memory end and misaligned ones.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        apply_reset();
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: fpc = 32'($urandom_range(0, 32767)) * 32'd4;
          5, 6:          fpc = 32'h1FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
          7:             fpc = 32'($urandom_range(0, 32767)) * 32'd4 + 32'($urandom_range(1, 3));
          default:       fpc = $urandom() & 32'hFFFF_FFFC;
        endcase
        step($urandom_range(0, 9) < 2, $urandom_range(0, 99) < 3, fpc,
             $urandom_range(0, 9) < 7, $urandom_range(0, 19) < 17);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
